alu_bist: RTL and testbench

ALU_BIST -- requirements
Module: alu_bist

---
 rtl/alu_bist.sv | 195 +++++++++++++++++++
 tb/tb_alu_bist.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_bist.sv
// alu_bist: built-in self test for a 32-bit ALU.
// Plays a fixed 8-entry vector table onto the ALU ports. Each vector is held
// for SETTLE_CYCLES+1 cycles, and the ALU's result and zero flag are checked
// at the last edge of that window. The block counts mismatches and records
// the index of the first one. Every output comes straight from a flop.
module alu_bist #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_on_fail,
  output logic [2:0]  ALU_Control,
  output logic [31:0] A,
  output logic [31:0] B,
  input  logic [31:0] ALU_result,
  input  logic        zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  err_count,
  output logic [2:0]  first_fail
);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);
  localparam logic [3:0] ERR_MAX     = 4'd8;

  // Operands presented to the ALU for each table entry.
  function automatic vec_t vec_ops(input logic [2:0] idx);
    case (idx)
      3'd0:    return '{op: OP_AND, a: 32'd1,          b: 32'd0};
      3'd1:    return '{op: OP_ADD, a: 32'd1,          b: 32'd0};
      3'd2:    return '{op: OP_OR,  a: 32'd1,          b: 32'd0};
      3'd3:    return '{op: OP_SLT, a: 32'd1,          b: 32'd0};
      3'd4:    return '{op: OP_SUB, a: 32'd10,         b: 32'd5};
      3'd5:    return '{op: OP_SUB, a: 32'd5,          b: 32'd10};
      3'd6:    return '{op: OP_SLT, a: 32'hFFFF_FFFF,  b: 32'd1};
      default: return '{op: OP_ADD, a: 32'hFFFF_FFFF,  b: 32'd1};
    endcase
  endfunction

  // Known-good result for each table entry.
  function automatic logic [31:0] vec_exp(input logic [2:0] idx);
    case (idx)
      3'd0:    return 32'd0;
      3'd1:    return 32'd1;
      3'd2:    return 32'd1;
      3'd3:    return 32'd0;
      3'd4:    return 32'd5;
      3'd5:    return 32'hFFFF_FFFB;
      3'd6:    return 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        halt_q, halt_d;
  logic [2:0]  ctl_q, ctl_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [3:0]  err_q, err_d;
  logic [2:0]  ff_q, ff_d;

  vec_t        first_vec, next_vec;
  logic [31:0] cur_exp;
  logic        mismatch;
  logic [3:0]  err_upd;

  assign first_vec = vec_ops(3'd0);
  assign next_vec  = vec_ops(idx_q + 3'd1);
  assign cur_exp   = vec_exp(idx_q);
  assign mismatch  = (ALU_result != cur_exp) || (zero != (cur_exp == 32'd0));
  assign err_upd   = (mismatch && err_q != ERR_MAX) ? err_q + 4'd1 : err_q;

  // Next-state, sequencing and result bookkeeping for the test run.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    halt_d  = halt_q;
    ctl_d   = ctl_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = HOLD;
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
          halt_d  = halt_on_fail;
          ctl_d   = first_vec.op;
          a_d     = first_vec.a;
          b_d     = first_vec.b;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = 4'd0;
          ff_d    = 3'd0;
        end
      end
      HOLD: begin
        if (cnt_q != SETTLE_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          err_d = err_upd;
          if (mismatch && err_q == 4'd0) ff_d = idx_q;
          if (idx_q == 3'd7 || (mismatch && halt_q)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_upd == 4'd0);
            ctl_d   = 3'd0;
            a_d     = 32'd0;
            b_d     = 32'd0;
          end else begin
            idx_d = idx_q + 3'd1;
            cnt_d = 4'd0;
            ctl_d = next_vec.op;
            a_d   = next_vec.a;
            b_d   = next_vec.b;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset; a reset drops any run in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      halt_q  <= 1'b0;
      ctl_q   <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 4'd0;
      ff_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      ctl_q   <= ctl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  assign ALU_Control = ctl_q;
  assign A           = a_q;
  assign B           = b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign first_fail  = ff_q;

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: self-checking bench for alu_bist.
// A behavioural ALU with injectable faults sits on the DUT's ALU ports. A run
// model built from the vector table predicts the outcome: the visible vector
// sequence, the mismatch count, the first failing index and the done time.
module tb_alu_bist;

  localparam int S1   = 1;
  localparam int HOLD = S1 + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic [2:0]  ctl;
  logic [31:0] a, b, res;
  logic        zr, busy, done, pass;
  logic [3:0]  errc;
  logic [2:0]  ff;

  logic        start3 = 1'b0;
  logic [2:0]  ctl3;
  logic [31:0] a3, b3, res3;
  logic        zr3, busy3, done3, pass3;
  logic [3:0]  errc3;
  logic [2:0]  ff3;

  // Fault injection: result = (ideal & and_mask) | or_mask; zmode 0 real, 1 stuck-0, 2 stuck-1.
  logic [31:0] and_mask = '1;
  logic [31:0] or_mask  = '0;
  int          zmode    = 0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b111:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign res  = (alu_ref(ctl, a, b) & and_mask) | or_mask;
  assign zr   = (zmode == 0) ? (res == 32'd0) : (zmode == 2);
  assign res3 = alu_ref(ctl3, a3, b3);
  assign zr3  = (res3 == 32'd0);

  alu_bist #(.SETTLE_CYCLES(S1)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_on_fail(halt),
    .ALU_Control(ctl), .A(a), .B(b), .ALU_result(res), .zero(zr),
    .busy(busy), .done(done), .pass(pass), .err_count(errc), .first_fail(ff)
  );

  alu_bist #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .halt_on_fail(1'b0),
    .ALU_Control(ctl3), .A(a3), .B(b3), .ALU_result(res3), .zero(zr3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(errc3), .first_fail(ff3)
  );

  // Vector table: op, A, B, expected result.
  logic [2:0]  tv_op  [8] = '{3'b000, 3'b010, 3'b001, 3'b111, 3'b110, 3'b110, 3'b111, 3'b010};
  logic [31:0] tv_a   [8] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd10, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] tv_b   [8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd5, 32'd10, 32'd1, 32'd1};
  logic [31:0] tv_exp [8] = '{32'd0, 32'd1, 32'd1, 32'd0, 32'd5, 32'hFFFF_FFFB, 32'd1, 32'd0};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " vec"}, {ctl, a, b}, '0);
    check({tag, " status"}, {busy, done, pass, errc, ff}, '0);
  endtask

  // One run of the S=1 DUT with the given fault. restart_at / reset_at: cycle
  // (after the start edge) at which start / reset is applied, or -1 for never.
  task automatic run_test(input string name, input logic [31:0] am, input logic [31:0] om,
                          input int zm, input logic h, input int restart_at, input int reset_at);
    int errs = 0, first = 0, n = 8, done_at;
    and_mask = am;
    or_mask  = om;
    zmode    = zm;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] r;
      logic        z, bad;
      r   = (alu_ref(tv_op[i], tv_a[i], tv_b[i]) & am) | om;
      z   = (zm == 0) ? (r == 32'd0) : (zm == 2);
      bad = (r != tv_exp[i]) || (z != (tv_exp[i] == 32'd0));
      if (bad) begin
        if (errs == 0) first = i;
        errs++;
        if (h) begin
          n = i + 1;
          break;
        end
      end
    end
    done_at = n * HOLD;

    @(posedge clk); #1;
    start = 1'b1;
    halt  = h;
    @(posedge clk); #1;
    start = 1'b0;
    halt  = ~h;  // must have been latched at the start edge
    for (int c = 0; c <= done_at; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      start = 1'b0;
      if (c == reset_at) begin
        reset = 1'b0;
        check_all_zero({name, " after reset"});
        halt = 1'b0;
        return;
      end
      if (c < done_at) begin
        check({name, " busy/done"}, {busy, done}, 2'b10);
        check({name, " vector"}, {ctl, a, b},
              {tv_op[c / HOLD], tv_a[c / HOLD], tv_b[c / HOLD]});
      end else begin
        check({name, " busy/done/pass"}, {busy, done, pass}, {1'b0, 1'b1, errs == 0});
        check({name, " err_count"}, errc, errs);
        if (errs != 0) check({name, " first_fail"}, ff, first);
        check({name, " idle vector"}, {ctl, a, b}, '0);
      end
      if (c + 1 == restart_at) start = 1'b1;
      if (c + 1 == reset_at) reset = 1'b1;
    end
    @(posedge clk); #1;
    check({name, " done held"}, {busy, done, errc}, {1'b0, 1'b1, 4'(errs)});
    halt = 1'b0;
  endtask

  initial begin
    int done_cycle;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset dut3", {busy3, done3, ctl3, a3, b3}, '0);

    // Reset beats start at the same edge.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    check_all_zero("reset over start");

    run_test("clean",     '1,             '0, 0, 1'b0, -1, -1);
    run_test("bit0 run",  32'hFFFF_FFFE,  '0, 0, 1'b0, -1, -1);
    run_test("bit0 halt", 32'hFFFF_FFFE,  '0, 0, 1'b1, -1, -1);
    run_test("zero stk0", '1,             '0, 1, 1'b0, -1, -1);
    run_test("restart",   '1,             '0, 0, 1'b0,  5, -1);
    run_test("rerun",     32'hFFFF_FFFE,  '0, 0, 1'b0, -1, -1);
    run_test("reset mid", '1,             '0, 0, 1'b0, -1,  7);
    run_test("post rst",  '1,             '0, 0, 1'b0, -1, -1);

    for (int k = 0; k < 8; k++) begin
      int          mode;
      logic [31:0] am, om;
      int          zm;
      logic        h;
      mode = $urandom_range(0, 3);
      am   = '1;
      om   = '0;
      zm   = 0;
      case (mode)
        1:       am = ~(32'd1 << $urandom_range(0, 31));
        2:       om = 32'd1 << $urandom_range(0, 31);
        3:       zm = $urandom_range(1, 2);
        default: ;
      endcase
      h = 1'($urandom_range(0, 1));
      run_test($sformatf("rand%0d", k), am, om, zm, h, -1, -1);
    end

    // SETTLE_CYCLES=3 instance: full clean run completes 32 cycles after start.
    @(posedge clk); #1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    done_cycle = -1;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (done3 && done_cycle < 0) done_cycle = c;
    end
    check("s3 done cycle", done_cycle, 32);
    check("s3 result", {pass3, errc3, busy3}, {1'b1, 4'd0, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
